median_3x3_mc: RTL and testbench

//  Parametrised 3x3 rank filter: per-channel median/min/max over a sliding
//  3x3 window, with line-aware window-valid tracking and a valid_out strobe.

---
 rtl/median_3x3_mc_if.sv | 25 ++
 rtl/median_3x3_mc.sv | 145 ++++++++++++++
 tb/tb_median_3x3_mc.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/median_3x3_mc_if.sv
// Pixel-beat bus of the 3x3 rank filter: three row taps, mode select and
// the filtered pixel with its valid / start-of-line strobes.
interface median_3x3_mc_if #(
    parameter int CW = 8,
    parameter int CH = 3
);
    logic                 valid_in;
    logic [CH*CW-1:0]     din1;
    logic [CH*CW-1:0]     din2;
    logic [CH*CW-1:0]     din3;
    logic [1:0]           mode;
    logic [CH*CW-1:0]     dout;
    logic                 valid_out;
    logic                 sol_out;

    modport master (
        output valid_in, din1, din2, din3, mode,
        input  dout, valid_out, sol_out
    );

    modport slave (
        input  valid_in, din1, din2, din3, mode,
        output dout, valid_out, sol_out
    );
endinterface

// File: rtl/median_3x3_mc.sv
// 3x3 per-channel rank filter (median / min / max / centre bypass).
// Stage 1 sorts each incoming column and shifts it into a 3-column window;
// stage 2 reduces the window to one pixel. Lines are delimited purely by
// the beat count, so valid_in gaps never disturb the column position.
module median_3x3_mc #(
    parameter int CW        = 8,
    parameter int CH        = 3,
    parameter int PIC_WIDTH = 640,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    median_3x3_mc_if.slave    bus
);

    localparam int W = CH * CW;

    function automatic logic [CW-1:0] min2(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a <= b) ? a : b;
    endfunction

    function automatic logic [CW-1:0] max2(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a <= b) ? b : a;
    endfunction

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [CW-1:0] med3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // window columns: index 0 is the newest column, 2 the oldest
    logic [W-1:0]     cmin_q [3];
    logic [W-1:0]     cmid_q [3];
    logic [W-1:0]     cmax_q [3];
    logic [W-1:0]     raw_q;        // raw din2 of the newest column
    logic [W-1:0]     centre_q;     // raw din2 of the window's middle column
    logic [CNT_W-1:0] col_cnt_q;
    logic [CNT_W-1:0] col_cnt_d;
    logic             s1_valid_q;
    logic             s1_sol_q;
    logic             win_full;

    logic [W-1:0]     smin_d, smid_d, smax_d;
    logic [W-1:0]     result_d;

    logic [W-1:0]     dout_q;
    logic             valid_q;
    logic             sol_q;

    assign win_full  = (col_cnt_q >= CNT_W'(2));
    assign col_cnt_d = (col_cnt_q == CNT_W'(PIC_WIDTH - 1)) ? '0 : col_cnt_q + CNT_W'(1);

    // sort the incoming column per channel into min / mid / max
    always_comb begin
        smin_d = '0;
        smid_d = '0;
        smax_d = '0;
        for (int c = 0; c < CH; c++) begin
            smin_d[c*CW +: CW] = min3(bus.din1[c*CW +: CW], bus.din2[c*CW +: CW], bus.din3[c*CW +: CW]);
            smid_d[c*CW +: CW] = med3(bus.din1[c*CW +: CW], bus.din2[c*CW +: CW], bus.din3[c*CW +: CW]);
            smax_d[c*CW +: CW] = max3(bus.din1[c*CW +: CW], bus.din2[c*CW +: CW], bus.din3[c*CW +: CW]);
        end
    end

    // stage 1: shift the window and track the column position on each beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                cmin_q[k] <= '0;
                cmid_q[k] <= '0;
                cmax_q[k] <= '0;
            end
            raw_q      <= '0;
            centre_q   <= '0;
            col_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_sol_q   <= 1'b0;
        end else begin
            s1_valid_q <= bus.valid_in && win_full;
            if (bus.valid_in) begin
                cmin_q[0] <= smin_d;
                cmid_q[0] <= smid_d;
                cmax_q[0] <= smax_d;
                for (int k = 1; k < 3; k++) begin
                    cmin_q[k] <= cmin_q[k-1];
                    cmid_q[k] <= cmid_q[k-1];
                    cmax_q[k] <= cmax_q[k-1];
                end
                raw_q     <= bus.din2;
                centre_q  <= raw_q;
                col_cnt_q <= col_cnt_d;
                s1_sol_q  <= (col_cnt_q == CNT_W'(2));
            end
        end
    end

    // reduce the window per channel according to mode
    always_comb begin
        result_d = '0;
        for (int c = 0; c < CH; c++) begin
            case (bus.mode)
                2'd0: result_d[c*CW +: CW] = med3(
                          min3(cmax_q[0][c*CW +: CW], cmax_q[1][c*CW +: CW], cmax_q[2][c*CW +: CW]),
                          med3(cmid_q[0][c*CW +: CW], cmid_q[1][c*CW +: CW], cmid_q[2][c*CW +: CW]),
                          max3(cmin_q[0][c*CW +: CW], cmin_q[1][c*CW +: CW], cmin_q[2][c*CW +: CW]));
                2'd1: result_d[c*CW +: CW] =
                          min3(cmin_q[0][c*CW +: CW], cmin_q[1][c*CW +: CW], cmin_q[2][c*CW +: CW]);
                2'd2: result_d[c*CW +: CW] =
                          max3(cmax_q[0][c*CW +: CW], cmax_q[1][c*CW +: CW], cmax_q[2][c*CW +: CW]);
                default: result_d[c*CW +: CW] = centre_q[c*CW +: CW];
            endcase
        end
    end

    // stage 2: register the result and emit single-cycle strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            sol_q   <= 1'b0;
        end else if (s1_valid_q) begin
            dout_q  <= result_d;
            valid_q <= 1'b1;
            sol_q   <= s1_sol_q;
        end else begin
            valid_q <= 1'b0;
            sol_q   <= 1'b0;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.valid_out = valid_q;
    assign bus.sol_out   = sol_q;

endmodule

// File: tb/tb_median_3x3_mc.sv
// Randomised check of median_3x3_mc against a sort-based window model.
module tb_median_3x3_mc;

    localparam int CW    = 8;
    localparam int CH    = 3;
    localparam int PW    = 8;
    localparam int CNT_W = 3;
    localparam int W     = CH * CW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    median_3x3_mc_if #(.CW(CW), .CH(CH)) bus ();

    median_3x3_mc #(.CW(CW), .CH(CH), .PIC_WIDTH(PW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int                cyc;
        logic [3:0][W-1:0] r;     // indexed by mode
        logic              sol;
    } exp_t;

    exp_t        q[$];
    logic [W-1:0] mt[3], mm[3], mb[3];   // model window, index 2 newest
    int          mcol;
    int          n_vec = 0, n_err = 0;
    int          res_cnt;
    logic [31:0] sol_mask;
    logic [W-1:0] last_dout;
    logic        last_sol;
    logic [1:0]  cur_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // rank-order reference: gather all nine samples, sort, pick by rank
    task automatic model_beat(input logic [W-1:0] d1, input logic [W-1:0] d2, input logic [W-1:0] d3);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            mt[k] = mt[k+1];
            mm[k] = mm[k+1];
            mb[k] = mb[k+1];
        end
        mt[2] = d1;
        mm[2] = d2;
        mb[2] = d3;
        if (mcol >= 2) begin
            e.cyc = cyc + 2;
            e.sol = (mcol == 2);
            e.r   = '0;
            for (int c = 0; c < CH; c++) begin
                int v[9];
                for (int k = 0; k < 3; k++) begin
                    v[3*k]   = int'(mt[k][c*CW +: CW]);
                    v[3*k+1] = int'(mm[k][c*CW +: CW]);
                    v[3*k+2] = int'(mb[k][c*CW +: CW]);
                end
                for (int i = 0; i < 9; i++)
                    for (int j = 0; j < 8 - i; j++)
                        if (v[j] > v[j+1]) begin
                            int t;
                            t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                        end
                e.r[0][c*CW +: CW] = CW'(v[4]);
                e.r[1][c*CW +: CW] = CW'(v[0]);
                e.r[2][c*CW +: CW] = CW'(v[8]);
                e.r[3][c*CW +: CW] = mm[1][c*CW +: CW];
            end
            q.push_back(e);
        end
        mcol = (mcol + 1) % PW;
    endtask

    task automatic check_out();
        logic ev;
        ev = (q.size() > 0) && (q[0].cyc == cyc);
        chk("valid_out", 32'(bus.valid_out), 32'(ev));
        if (ev) begin
            chk("dout", 32'(bus.dout), 32'(q[0].r[cur_mode]));
            chk("sol_out", 32'(bus.sol_out), 32'(q[0].sol));
            void'(q.pop_front());
        end else begin
            chk("sol_idle", 32'(bus.sol_out), 32'd0);
        end
        if (bus.valid_out) begin
            last_dout = bus.dout;
            last_sol  = bus.sol_out;
            if (bus.sol_out && res_cnt < 32) sol_mask[res_cnt] = 1'b1;
            res_cnt++;
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d1, input logic [W-1:0] d2,
                        input logic [W-1:0] d3, input logic [1:0] m);
        bus.valid_in = v;
        bus.din1     = d1;
        bus.din2     = d2;
        bus.din3     = d3;
        bus.mode     = m;
        cur_mode     = m;
        if (v) model_beat(d1, d2, d3);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, cur_mode);
    endtask

    // assert reset mid-cycle and check that the outputs clear without a clock
    task automatic do_reset();
        #2;
        rst_n        = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_dout",  32'(bus.dout),      32'd0);
        chk("rst_sol",   32'(bus.sol_out),   32'd0);
        q.delete();
        mcol = 0;
        for (int k = 0; k < 3; k++) begin
            mt[k] = '0; mm[k] = '0; mb[k] = '0;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        res_cnt   = 0;
        sol_mask  = '0;
        last_dout = '0;
        last_sol  = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_px();
        logic [W-1:0] p;
        for (int c = 0; c < CH; c++)
            p[c*CW +: CW] = ($urandom_range(0, 1) == 0) ? CW'($urandom_range(0, 3)) : CW'($urandom);
        return p;
    endfunction

    int t1_exp[4] = '{5, 1, 9, 8};

    initial begin
        bus.valid_in = 1'b0;
        bus.din1     = '0;
        bus.din2     = '0;
        bus.din3     = '0;
        bus.mode     = 2'd0;
        cur_mode     = 2'd0;
        mcol         = 0;
        res_cnt      = 0;
        sol_mask     = '0;
        #1;

        // single window under each mode, identical on all channels
        for (int m = 0; m < 4; m++) begin
            do_reset();
            step(1'b1, {3{8'd9}}, {3{8'd1}}, {3{8'd5}}, 2'(m));
            step(1'b1, {3{8'd2}}, {3{8'd8}}, {3{8'd3}}, 2'(m));
            step(1'b1, {3{8'd7}}, {3{8'd4}}, {3{8'd6}}, 2'(m));
            step(1'b0, '0, '0, '0, 2'(m));
            chk("t1_dout", 32'(last_dout), 32'({3{8'(t1_exp[m])}}));
            chk("t1_sol", 32'(last_sol), 32'd1);
        end

        // independent channels: R ramp, G flat, B with one dark sample
        do_reset();
        step(1'b1, {8'hFF, 8'h80, 8'd10}, {8'hFF, 8'h80, 8'd11}, {8'hFF, 8'h80, 8'd12}, 2'd0);
        step(1'b1, {8'hFF, 8'h80, 8'd13}, {8'h00, 8'h80, 8'd14}, {8'hFF, 8'h80, 8'd15}, 2'd0);
        step(1'b1, {8'hFF, 8'h80, 8'd16}, {8'hFF, 8'h80, 8'd17}, {8'hFF, 8'h80, 8'd18}, 2'd0);
        step(1'b0, '0, '0, '0, 2'd0);
        chk("t3_dout", 32'(last_dout), 32'h00FF800E);

        // two back-to-back lines
        do_reset();
        for (int i = 0; i < 2 * PW; i++) step(1'b1, rnd_px(), rnd_px(), rnd_px(), 2'd0);
        idle(2);
        chk("t4_results", 32'(res_cnt), 32'd12);
        chk("t4_sol_pos", sol_mask, 32'h0000_0041);

        // random gaps and modes
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 40), rnd_px(), rnd_px(), rnd_px(), 2'($urandom_range(0, 3)));
        end
        idle(2);
        chk("t5_drain", 32'(q.size()), 32'd0);

        // reset in the middle of a line, then restart at column 0
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, rnd_px(), rnd_px(), rnd_px(), 2'd0);
        chk("t6_pre_valid", 32'(bus.valid_out), 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, rnd_px(), rnd_px(), rnd_px(), 2'd0);
        chk("t6_no_early", 32'(res_cnt), 32'd0);
        idle(1);
        chk("t6_first", 32'(res_cnt), 32'd1);
        chk("t6_first_sol", 32'(last_sol), 32'd1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
